// File: rtl/bus_slave_mem.sv
// Bus slave with separate memory and I/O word arrays behind an ALE/RD_N/WR_N
// multiplexed-style bus, with programmable wait states and range checking.
// RD_N and WR_N are registered before the FSM sees them. "Sampled at edge k"
// therefore means the FSM acts on the strobe at edge k+1, which gives the read
// latency of WAIT_STATES+2 edges.
// Ports:
//   CLK, RESET_N      clock, asynchronous active-low reset
//   ALE, Address, IOM address latch enable, address, space select (1 = I/O)
//   RD_N, WR_N        active-low read/write strobes
//   AD                write data
//   Data              registered read data
//   OE                read data valid (HOLD of a successful read)
//   READY             low while inserting wait states
//   ERR               high for the ACCESS cycle of an out-of-range access
module bus_slave_mem #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned MEM_DEPTH   = 1024,
  parameter int unsigned IO_DEPTH    = 256,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  ALE,
  input  logic                  RD_N,
  input  logic                  WR_N,
  input  logic                  IOM,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [DATA_WIDTH-1:0] AD,
  output logic [DATA_WIDTH-1:0] Data,
  output logic                  OE,
  output logic                  READY,
  output logic                  ERR
);

  localparam int unsigned MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int unsigned IO_AW  = (IO_DEPTH > 1) ? $clog2(IO_DEPTH) : 1;
  localparam int unsigned CNT_W  = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD =
    (WAIT_STATES == 0) ? CNT_W'(0) : CNT_W'(WAIT_STATES - 1);

  // One-hot state bit positions.
  localparam int unsigned B_WAIT   = 2;
  localparam int unsigned B_ACCESS = 3;
  localparam int unsigned B_HOLD   = 4;

  typedef enum logic [4:0] {
    ST_IDLE   = 5'b00001,
    ST_ADDR   = 5'b00010,
    ST_WAIT   = 5'b00100,
    ST_ACCESS = 5'b01000,
    ST_HOLD   = 5'b10000
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    iom_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    is_rd_q;
  logic                    rd_s;
  logic                    wr_s;
  logic                    strobe_act;
  logic                    oor;
  logic [MEM_AW-1:0]       mem_idx;
  logic [IO_AW-1:0]        io_idx;

  logic [DATA_WIDTH-1:0]   mem_array [MEM_DEPTH];
  logic [DATA_WIDTH-1:0]   io_array  [IO_DEPTH];

  // Address decode of the latched address into the selected space.
  assign oor = iom_q ? (32'(addr_q) >= IO_DEPTH) : (32'(addr_q) >= MEM_DEPTH);
  assign mem_idx = MEM_AW'(addr_q);
  assign io_idx  = IO_AW'(addr_q);
  // The strobe that belongs to the access in flight.
  assign strobe_act = is_rd_q ? rd_s : wr_s;

  // State register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (ALE) state_d = ST_ADDR;
      end
      ST_ADDR: begin
        // ALE has priority: a repeated ALE relatches and stays here.
        if (!ALE && (rd_s || wr_s)) begin
          state_d = (WAIT_STATES == 0) ? ST_ACCESS : ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A released strobe aborts even on the last wait cycle.
        if (!strobe_act)         state_d = ST_IDLE;
        else if (cnt_q == '0)    state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (!strobe_act) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from registered state and latched cycle attributes.
  always_comb begin
    READY = ~state_q[B_WAIT];
    OE    = state_q[B_HOLD] & is_rd_q & ~oor;
    ERR   = state_q[B_ACCESS] & oor;
  end

  // Strobe sampling, address latch, wait counter and read data register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rd_s    <= 1'b0;
      wr_s    <= 1'b0;
      addr_q  <= '0;
      iom_q   <= 1'b0;
      cnt_q   <= '0;
      is_rd_q <= 1'b0;
      Data    <= '0;
    end else begin
      rd_s <= ~RD_N;
      wr_s <= ~WR_N;
      if ((state_q == ST_IDLE || state_q == ST_ADDR) && ALE) begin
        addr_q <= Address;
        iom_q  <= IOM;
      end
      // Read wins when both strobes are active.
      if (state_q == ST_ADDR && !ALE && (rd_s || wr_s)) begin
        is_rd_q <= rd_s;
        cnt_q   <= CNT_LOAD;
      end
      if (state_q == ST_WAIT && cnt_q != '0) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (state_q == ST_ACCESS && is_rd_q && !oor) begin
        Data <= iom_q ? io_array[io_idx] : mem_array[mem_idx];
      end
    end
  end

  // Storage arrays: not reset; written only in the single ACCESS cycle.
  always_ff @(posedge CLK) begin
    if (state_q == ST_ACCESS && !is_rd_q && !oor) begin
      if (iom_q) io_array[io_idx]   <= AD;
      else       mem_array[mem_idx] <= AD;
    end
  end

endmodule

// File: tb/tb_bus_slave_mem.sv
// Testbench for bus_slave_mem: a WAIT_STATES=2 instance and a WAIT_STATES=0
// instance share one stimulus bus, and sel chooses which instance sees it.
// A word-level reference model covers a small memory/I-O region.
module tb_bus_slave_mem;

  logic       CLK;
  logic       RESET_N;
  logic       ALE;
  logic       RD_N;
  logic       WR_N;
  logic       IOM;
  logic [9:0] Address;
  logic [7:0] AD;
  logic       sel;

  logic       ale2, rd2, wr2, ale0, rd0, wr0;
  logic [7:0] data2, data0, data_o;
  logic       oe2, ready2, err2, oe0, ready0, err0;
  logic       oe_o, ready_o, err_o;

  assign ale2 = ALE & ~sel;
  assign rd2  = RD_N | sel;
  assign wr2  = WR_N | sel;
  assign ale0 = ALE & sel;
  assign rd0  = RD_N | ~sel;
  assign wr0  = WR_N | ~sel;

  assign data_o  = sel ? data0  : data2;
  assign oe_o    = sel ? oe0    : oe2;
  assign ready_o = sel ? ready0 : ready2;
  assign err_o   = sel ? err0   : err2;

  bus_slave_mem #(.ADDR_WIDTH(10), .DATA_WIDTH(8), .MEM_DEPTH(1024),
                  .IO_DEPTH(256), .WAIT_STATES(2)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .ALE(ale2), .RD_N(rd2), .WR_N(wr2),
    .IOM(IOM), .Address(Address), .AD(AD),
    .Data(data2), .OE(oe2), .READY(ready2), .ERR(err2)
  );

  bus_slave_mem #(.ADDR_WIDTH(10), .DATA_WIDTH(8), .MEM_DEPTH(1024),
                  .IO_DEPTH(256), .WAIT_STATES(0)) dut0 (
    .CLK(CLK), .RESET_N(RESET_N), .ALE(ale0), .RD_N(rd0), .WR_N(wr0),
    .IOM(IOM), .Address(Address), .AD(AD),
    .Data(data0), .OE(oe0), .READY(ready0), .ERR(err0)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: per instance, memory words 0..31 and I/O words 0..15,
  // plus the expected content of the Data register.
  logic [7:0] mem_m [2][32];
  logic [7:0] io_m  [2][16];
  logic [7:0] data_m [2];

  int n_tests;
  int n_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One bus access. mode 0: full access then release; mode 1: release the
  // strobe in the first wait cycle (abort); mode 2: stop in HOLD, strobe low.
  task automatic bus_cycle(input bit rd, input bit iom, input logic [9:0] addr,
                           input logic [7:0] wd, input int mode, input bit relatch);
    int         ws;
    int         s;
    bit         oor;
    bit         ok;
    logic [7:0] word_e;
    logic [7:0] data_e;
    s  = sel ? 1 : 0;
    ws = sel ? 0 : 2;
    oor = iom && (addr >= 10'h100);
    ok  = !oor && (mode != 1);
    word_e = 8'h00;
    if (!oor) word_e = iom ? io_m[s][addr[3:0]] : mem_m[s][addr[4:0]];

    @(posedge CLK); #1;
    ALE = 1'b1;
    AD  = wd;
    if (relatch) begin
      Address = addr ^ 10'h003;
      IOM     = ~iom;
      @(posedge CLK); #1;
    end
    Address = addr;
    IOM     = iom;
    @(posedge CLK); #1;
    ALE     = 1'b0;
    Address = 10'($urandom);
    IOM     = 1'($urandom);
    if (rd) RD_N = 1'b0;
    else    WR_N = 1'b0;

    // c = number of edges since the strobe was first sampled low.
    for (int c = 0; c <= ws + 2; c++) begin
      @(posedge CLK);
      @(negedge CLK);
      data_e = (ok && rd && c == ws + 2) ? word_e : data_m[s];
      check("ready", 32'(ready_o), 32'((c >= 1 && c <= ws) ? 1'b0 : 1'b1));
      check("err",   32'(err_o),   32'(mode != 1 && oor && c == ws + 1));
      check("oe",    32'(oe_o),    32'(ok && rd && c == ws + 2));
      check("data",  32'(data_o),  32'(data_e));
      if (mode == 1 && c == 1) begin
        RD_N = 1'b1;
        WR_N = 1'b1;
      end
    end

    if (ok) begin
      if (rd)       data_m[s] = word_e;
      else if (iom) io_m[s][addr[3:0]]  = wd;
      else          mem_m[s][addr[4:0]] = wd;
    end

    if (mode == 0) begin
      // Changing AD during HOLD exposes any second write.
      AD = ~wd;
      for (int h = 0; h < 2; h++) begin
        @(negedge CLK);
        check("hold_oe",    32'(oe_o),    32'(ok && rd));
        check("hold_ready", 32'(ready_o), 32'(1));
        check("hold_data",  32'(data_o),  32'(data_m[s]));
      end
      RD_N = 1'b1;
      WR_N = 1'b1;
      @(negedge CLK);
      check("rel_oe", 32'(oe_o), 32'(ok && rd));
      @(negedge CLK);
      check("idle_oe",    32'(oe_o),    32'(0));
      check("idle_ready", 32'(ready_o), 32'(1));
    end
  endtask

  initial begin
    bit         rd;
    bit         iom;
    logic [9:0] addr;
    int         mode;

    n_tests = 0;
    n_fail  = 0;
    sel     = 1'b0;
    RESET_N = 1'b0;
    ALE     = 1'b0;
    RD_N    = 1'b1;
    WR_N    = 1'b1;
    IOM     = 1'b0;
    Address = '0;
    AD      = '0;
    data_m[0] = 8'h00;
    data_m[1] = 8'h00;

    // Reset state of both instances.
    repeat (3) @(negedge CLK);
    check("rst_oe",     32'(oe2),    32'(0));
    check("rst_ready",  32'(ready2), 32'(1));
    check("rst_err",    32'(err2),   32'(0));
    check("rst_data",   32'(data2),  32'(0));
    check("rst0_oe",    32'(oe0),    32'(0));
    check("rst0_ready", 32'(ready0), 32'(1));
    check("rst0_err",   32'(err0),   32'(0));
    check("rst0_data",  32'(data0),  32'(0));
    RESET_N = 1'b1;

    // Fill the modelled region with known contents.
    for (int a = 0; a < 32; a++) bus_cycle(1'b0, 1'b0, 10'(a), 8'($urandom), 0, 1'b0);
    for (int a = 0; a < 16; a++) bus_cycle(1'b0, 1'b1, 10'(a), 8'($urandom), 0, 1'b0);

    // Memory write then read of 0x010.
    bus_cycle(1'b0, 1'b0, 10'h010, 8'hA5, 0, 1'b0);
    bus_cycle(1'b1, 1'b0, 10'h010, 8'h00, 0, 1'b0);
    // I/O space write/read; same offset in memory is untouched.
    bus_cycle(1'b0, 1'b1, 10'h005, 8'h3C, 0, 1'b0);
    bus_cycle(1'b1, 1'b1, 10'h005, 8'h00, 0, 1'b0);
    bus_cycle(1'b1, 1'b0, 10'h005, 8'h00, 0, 1'b0);
    // Out-of-range I/O write and read; io[0] must not be aliased.
    bus_cycle(1'b0, 1'b1, 10'h100, 8'hFF, 0, 1'b0);
    bus_cycle(1'b1, 1'b1, 10'h1FF, 8'h00, 0, 1'b0);
    bus_cycle(1'b1, 1'b1, 10'h000, 8'h00, 0, 1'b0);
    // Address relatch in ADDR.
    bus_cycle(1'b1, 1'b1, 10'h005, 8'h00, 0, 1'b1);
    // Aborted write and read in WAIT leave the word intact.
    bus_cycle(1'b0, 1'b0, 10'h010, 8'h5A, 1, 1'b0);
    bus_cycle(1'b1, 1'b0, 10'h010, 8'h00, 1, 1'b0);
    bus_cycle(1'b1, 1'b0, 10'h010, 8'h00, 0, 1'b0);

    // Reset in HOLD of a read.
    bus_cycle(1'b1, 1'b0, 10'h010, 8'h00, 2, 1'b0);
    #2 RESET_N = 1'b0;
    #1;
    check("hold_rst_oe",    32'(oe2),    32'(0));
    check("hold_rst_ready", 32'(ready2), 32'(1));
    check("hold_rst_err",   32'(err2),   32'(0));
    check("hold_rst_data",  32'(data2),  32'(0));
    data_m[0] = 8'h00;
    data_m[1] = 8'h00;
    RD_N = 1'b1;
    @(negedge CLK);
    RESET_N = 1'b1;
    // Array content survives reset.
    bus_cycle(1'b1, 1'b0, 10'h010, 8'h00, 0, 1'b0);

    // Randomized accesses against the model.
    for (int n = 0; n < 60; n++) begin
      rd  = 1'($urandom);
      iom = 1'($urandom);
      if (!iom)                  addr = 10'($urandom_range(31, 0));
      else if ($urandom % 4 != 0) addr = 10'($urandom_range(15, 0));
      else                       addr = 10'($urandom_range(1023, 256));
      mode = ($urandom % 5 == 0) ? 1 : 0;
      bus_cycle(rd, iom, addr, 8'($urandom), mode, 1'($urandom));
    end

    // Zero-wait-state instance.
    @(negedge CLK);
    sel = 1'b1;
    bus_cycle(1'b0, 1'b0, 10'h003, 8'h77, 0, 1'b0);
    bus_cycle(1'b1, 1'b0, 10'h003, 8'h00, 0, 1'b0);
    bus_cycle(1'b0, 1'b1, 10'h002, 8'h11, 0, 1'b0);
    bus_cycle(1'b1, 1'b1, 10'h002, 8'h00, 0, 1'b0);
    bus_cycle(1'b1, 1'b1, 10'h2AB, 8'h00, 0, 1'b0);
    bus_cycle(1'b1, 1'b0, 10'h003, 8'h00, 0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
